// File: rtl/cordic_wrapper_pkg.sv
// cordic_wrapper_pkg: shared CORDIC result type and output-buffer sizing
package cordic_wrapper_pkg;
  localparam int CORDIC_W = 16;
  localparam int CORDIC_OBUF_DEPTH = 8;
  typedef struct packed {
    logic signed [CORDIC_W-1:0] x;
    logic signed [CORDIC_W-1:0] y;
    logic signed [CORDIC_W-1:0] z;
  } cordic_data;
endpackage

// File: rtl/cordic_out_buffer_if.sv
// cordic_out_buffer_if: issue, pipeline-result and consumer handshakes of the output buffer
interface cordic_out_buffer_if
  import cordic_wrapper_pkg::*;
#(
  parameter int DEPTH = CORDIC_OBUF_DEPTH
) ();
  localparam int CW = $clog2(DEPTH + 1);
  logic          i_req_valid;
  logic          o_req_ready;
  logic          o_cordic_valid;
  logic          i_res_valid;
  cordic_data    i_res_data;
  logic          o_valid;
  cordic_data    o_data;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_err;
  modport slave (
    input  i_req_valid, i_res_valid, i_res_data, i_ready,
    output o_req_ready, o_cordic_valid, o_valid, o_data, o_count, o_err
  );
  modport master (
    output i_req_valid, i_res_valid, i_res_data, i_ready,
    input  o_req_ready, o_cordic_valid, o_valid, o_data, o_count, o_err
  );
endinterface

// File: rtl/cordic_sync_fifo.sv
// cordic_sync_fifo: show-ahead in-order FIFO; push into a full FIFO is accepted only alongside a pop
module cordic_sync_fifo
  import cordic_wrapper_pkg::*;
#(
  parameter int  DEPTH = CORDIC_OBUF_DEPTH,
  parameter type T     = cordic_data
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  T                           i_data,
  output T                           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc, pop_acc;
  // accept pop only when non-empty, push when space exists or the head leaves this cycle
  always_comb begin
    pop_acc  = i_pop && !o_empty;
    push_acc = i_push && (!o_full || pop_acc);
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_acc) - CW'(pop_acc);
  end
  // bookkeeping registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= i_data;
  end
  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = count_q == FULL_CNT;
  assign o_empty = count_q == '0;
  assign o_count = count_q;
endmodule

// File: rtl/cordic_out_buffer.sv
// cordic_out_buffer: credit-gated issue into the CORDIC pipeline plus in-order result buffering
module cordic_out_buffer
  import cordic_wrapper_pkg::*;
#(
  parameter int DEPTH = CORDIC_OBUF_DEPTH
) (
  input logic                i_clk,
  input logic                i_rst,
  cordic_out_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  logic [CW-1:0] in_flight_q, in_flight_d, count;
  logic          err_q, err_d;
  logic          full, empty, pop, issue, req_ready, spurious, dropped;
  // credits come only from registered counters so ready never sees i_ready/i_res_valid
  always_comb begin
    req_ready   = ({1'b0, count} + {1'b0, in_flight_q}) < DEPTH_W;
    issue       = bus.i_req_valid && req_ready;
    pop         = !empty && bus.i_ready;
    spurious    = bus.i_res_valid && in_flight_q == '0;
    dropped     = bus.i_res_valid && full && !pop;
    in_flight_d = in_flight_q + CW'(issue) - CW'(bus.i_res_valid && !spurious);
    err_d       = err_q || spurious || dropped;
  end
  // in-flight counter and sticky error flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end
  cordic_sync_fifo #(.DEPTH(DEPTH), .T(cordic_data)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.i_res_valid),
    .i_pop   (pop),
    .i_data  (bus.i_res_data),
    .o_data  (bus.o_data),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );
  assign bus.o_req_ready    = req_ready;
  assign bus.o_cordic_valid = issue;
  assign bus.o_valid        = !empty;
  assign bus.o_count        = count;
  assign bus.o_err          = err_q;
endmodule

// File: tb/tb_cordic_out_buffer.sv
// tb_cordic_out_buffer: directed vector table plus reset corner sequences for the output buffer
module tb_cordic_out_buffer;
  import cordic_wrapper_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic        rv, resv, rdy;
    logic [47:0] d;
    logic        e_valid;
    logic [2:0]  e_count;
    logic        e_rr, e_cv, e_err;
    logic [47:0] e_data;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  int   n_chk = 0, n_fail = 0;
  vec_t vec [31];
  cordic_out_buffer_if #(.DEPTH(DEPTH)) bus ();
  cordic_out_buffer #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(logic rv, logic resv, logic [47:0] d, logic rdy, logic ev,
                             logic [2:0] ec, logic rr, logic cv, logic er, logic [47:0] ed);
    vec_t t;
    t.rv = rv; t.resv = resv; t.d = d; t.rdy = rdy;
    t.e_valid = ev; t.e_count = ec; t.e_rr = rr; t.e_cv = cv; t.e_err = er; t.e_data = ed;
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask
  task automatic drive(logic rv, logic resv, logic [47:0] d, logic rdy);
    bus.i_req_valid = rv;
    bus.i_res_valid = resv;
    bus.i_res_data  = d;
    bus.i_ready     = rdy;
  endtask
  task automatic chk_state(string tag, logic ev, logic [2:0] ec, logic rr, logic er);
    chk({tag, ".o_valid"}, 64'(bus.o_valid), 64'(ev));
    chk({tag, ".o_count"}, 64'(bus.o_count), 64'(ec));
    chk({tag, ".o_req_ready"}, 64'(bus.o_req_ready), 64'(rr));
    chk({tag, ".o_err"}, 64'(bus.o_err), 64'(er));
  endtask
  initial begin
    // rows: inputs for the cycle, outputs expected before that cycle's edge
    vec[0]  = v(1, 0, 48'h0,  0, 0, 0, 1, 1, 0, 48'h0);
    vec[1]  = v(1, 0, 48'h0,  0, 0, 0, 1, 1, 0, 48'h0);
    vec[2]  = v(1, 0, 48'h0,  0, 0, 0, 1, 1, 0, 48'h0);
    vec[3]  = v(1, 0, 48'h0,  0, 0, 0, 1, 1, 0, 48'h0);
    vec[4]  = v(1, 0, 48'h0,  0, 0, 0, 0, 0, 0, 48'h0);
    vec[5]  = v(1, 0, 48'h0,  0, 0, 0, 0, 0, 0, 48'h0);
    vec[6]  = v(0, 1, 48'hA,  0, 0, 0, 0, 0, 0, 48'h0);
    vec[7]  = v(0, 1, 48'hB,  0, 1, 1, 0, 0, 0, 48'hA);
    vec[8]  = v(0, 1, 48'hC,  0, 1, 2, 0, 0, 0, 48'hA);
    vec[9]  = v(0, 1, 48'hD,  0, 1, 3, 0, 0, 0, 48'hA);
    vec[10] = v(0, 0, 48'h0,  1, 1, 4, 0, 0, 0, 48'hA);
    vec[11] = v(0, 0, 48'h0,  1, 1, 3, 1, 0, 0, 48'hB);
    vec[12] = v(1, 0, 48'h0,  0, 1, 2, 1, 1, 0, 48'hC);
    vec[13] = v(1, 1, 48'hE,  1, 1, 2, 1, 1, 0, 48'hC);
    vec[14] = v(1, 1, 48'hF,  1, 1, 2, 1, 1, 0, 48'hD);
    vec[15] = v(1, 1, 48'h10, 1, 1, 2, 1, 1, 0, 48'hE);
    vec[16] = v(0, 1, 48'h11, 1, 1, 2, 1, 0, 0, 48'hF);
    vec[17] = v(0, 0, 48'h0,  1, 1, 2, 1, 0, 0, 48'h10);
    vec[18] = v(0, 0, 48'h0,  1, 1, 1, 1, 0, 0, 48'h11);
    vec[19] = v(0, 0, 48'h0,  0, 0, 0, 1, 0, 0, 48'h0);
    vec[20] = v(0, 1, 48'h55, 0, 0, 0, 1, 0, 0, 48'h0);
    vec[21] = v(0, 1, 48'h66, 0, 1, 1, 1, 0, 1, 48'h55);
    vec[22] = v(0, 1, 48'h77, 0, 1, 2, 1, 0, 1, 48'h55);
    vec[23] = v(0, 1, 48'h78, 0, 1, 3, 1, 0, 1, 48'h55);
    vec[24] = v(0, 1, 48'h99, 0, 1, 4, 0, 0, 1, 48'h55);
    vec[25] = v(0, 1, 48'h9A, 1, 1, 4, 0, 0, 1, 48'h55);
    vec[26] = v(0, 0, 48'h0,  1, 1, 4, 0, 0, 1, 48'h66);
    vec[27] = v(0, 0, 48'h0,  1, 1, 3, 1, 0, 1, 48'h77);
    vec[28] = v(0, 0, 48'h0,  1, 1, 2, 1, 0, 1, 48'h78);
    vec[29] = v(0, 0, 48'h0,  1, 1, 1, 1, 0, 1, 48'h9A);
    vec[30] = v(0, 0, 48'h0,  0, 0, 0, 1, 0, 1, 48'h0);
    drive(0, 0, 48'h0, 0);
    #1 chk_state("reset_hold", 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_state("reset_release", 0, 0, 1, 0);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(vec[i].rv, vec[i].resv, vec[i].d, vec[i].rdy);
      #1;
      chk_state($sformatf("vec%0d", i), vec[i].e_valid, vec[i].e_count, vec[i].e_rr, vec[i].e_err);
      chk($sformatf("vec%0d.o_cordic_valid", i), 64'(bus.o_cordic_valid), 64'(vec[i].e_cv));
      if (vec[i].e_valid) chk($sformatf("vec%0d.o_data", i), 64'(bus.o_data), 64'(vec[i].e_data));
    end
    // build up one buffered entry and one in-flight op, then reset mid-cycle
    @(negedge clk);
    drive(1, 1, 48'h123, 0);
    @(negedge clk);
    drive(0, 0, 48'h0, 0);
    #1 chk_state("pre_async", 1, 1, 1, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_state("async_reset", 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    // the discarded op's result arrives after release and must be flagged
    @(negedge clk);
    drive(0, 1, 48'h77, 0);
    #1 chk_state("late_result_pre", 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 48'h0, 0);
    #1 chk_state("late_result_post", 1, 1, 1, 1);
    chk("late_result.o_data", 64'(bus.o_data), 64'h77);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
